// File: rtl/morse_stream_encoder.sv
// rtl/morse_stream_encoder.sv - buffered Morse keyer with FIFO, repeat and abort
//
// Purpose: stores a stream of symbols (digits, letters, word space) and keys
// them out on key_out with ITU unit timing once start is pulsed.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   sym_data/valid/ready    symbol write handshake (codes 0-36 stored)
//   start, abort, repeat_en keying control
//   key_out                 Morse key, high = mark
//   busy, done              keying status, completion pulse
//   err_invalid             pulse one cycle after an accepted invalid offer
//   fifo_count              number of symbols buffered
module morse_stream_encoder #(
    parameter int  UNIT_CYCLES = 10_000_000,
    parameter int  DEPTH       = 16,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [5:0]    sym_data,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  logic          start,
    input  logic          abort,
    input  logic          repeat_en,
    output logic          key_out,
    output logic          busy,
    output logic          done,
    output logic          err_invalid,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(UNIT_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);
    localparam logic [5:0]    SPACE    = 6'd36;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MARK, S_ELEM_GAP, S_CHAR_GAP, S_WORD_GAP, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pre, pre_nxt;
    logic [2:0]      units, units_nxt;   // units remaining after the current one
    logic [2:0]      elem, elem_nxt;     // index of the current element in pat
    logic [4:0]      pat, pat_nxt;       // 1 = dash, first element at bit len-1
    logic [AW-1:0]   rd_idx, rd_nxt;
    logic            loop_gap, loop_nxt; // current WORD_GAP is the repeat loop-back
    logic [CW-1:0]   count;
    logic            err_q;
    logic [5:0]      mem [DEPTH];

    logic            unit_end, seg_end, last_sym, flush, enter, enter_next, end_msg;
    logic            wr_offer, wr_ok;
    logic [5:0]      sym_cur, sym_next, ent_sym;
    logic [7:0]      ent_code;
    logic [2:0]      ent_len;
    logic [4:0]      ent_pat;

    // {length, pattern}; pattern right-aligned, first element in the highest used bit
    function automatic logic [7:0] lookup(input logic [5:0] code);
        case (code)
            6'd0:  lookup = {3'd5, 5'b11111};
            6'd1:  lookup = {3'd5, 5'b01111};
            6'd2:  lookup = {3'd5, 5'b00111};
            6'd3:  lookup = {3'd5, 5'b00011};
            6'd4:  lookup = {3'd5, 5'b00001};
            6'd5:  lookup = {3'd5, 5'b00000};
            6'd6:  lookup = {3'd5, 5'b10000};
            6'd7:  lookup = {3'd5, 5'b11000};
            6'd8:  lookup = {3'd5, 5'b11100};
            6'd9:  lookup = {3'd5, 5'b11110};
            6'd10: lookup = {3'd2, 5'b00001}; // A
            6'd11: lookup = {3'd4, 5'b01000}; // B
            6'd12: lookup = {3'd4, 5'b01010}; // C
            6'd13: lookup = {3'd3, 5'b00100}; // D
            6'd14: lookup = {3'd1, 5'b00000}; // E
            6'd15: lookup = {3'd4, 5'b00010}; // F
            6'd16: lookup = {3'd3, 5'b00110}; // G
            6'd17: lookup = {3'd4, 5'b00000}; // H
            6'd18: lookup = {3'd2, 5'b00000}; // I
            6'd19: lookup = {3'd4, 5'b00111}; // J
            6'd20: lookup = {3'd3, 5'b00101}; // K
            6'd21: lookup = {3'd4, 5'b00100}; // L
            6'd22: lookup = {3'd2, 5'b00011}; // M
            6'd23: lookup = {3'd2, 5'b00010}; // N
            6'd24: lookup = {3'd3, 5'b00111}; // O
            6'd25: lookup = {3'd4, 5'b00110}; // P
            6'd26: lookup = {3'd4, 5'b01101}; // Q
            6'd27: lookup = {3'd3, 5'b00010}; // R
            6'd28: lookup = {3'd3, 5'b00000}; // S
            6'd29: lookup = {3'd1, 5'b00001}; // T
            6'd30: lookup = {3'd3, 5'b00001}; // U
            6'd31: lookup = {3'd4, 5'b00001}; // V
            6'd32: lookup = {3'd3, 5'b00011}; // W
            6'd33: lookup = {3'd4, 5'b01001}; // X
            6'd34: lookup = {3'd4, 5'b01011}; // Y
            6'd35: lookup = {3'd4, 5'b01100}; // Z
            default: lookup = 8'd0;
        endcase
    endfunction

    assign busy        = (state != S_IDLE);
    assign key_out     = (state == S_MARK);
    assign done        = (state == S_DONE);
    assign err_invalid = err_q;
    assign fifo_count  = count;

    assign sym_ready = !busy && (count < CW'(DEPTH));
    assign wr_offer  = sym_valid && sym_ready;
    assign wr_ok     = wr_offer && (sym_data <= SPACE);

    assign unit_end = (pre == PRE_LAST);
    assign seg_end  = unit_end && (units == 3'd0);
    assign last_sym = (({1'b0, rd_idx} + CW'(1)) == count);

    // The symbol is always stored at index 0 upward; the head never moves,
    // so the read index can wrap back to 0 for repeat mode.
    assign sym_cur  = mem[rd_idx];
    assign sym_next = mem[rd_idx + AW'(1)];
    assign ent_sym  = enter_next ? sym_next : sym_cur;
    assign ent_code = lookup(ent_sym);
    assign ent_len  = ent_code[7:5];
    assign ent_pat  = ent_code[4:0];

    // Between symbols the next one is looked up during the last cycle of the
    // preceding segment, so LOAD is only visited at start and after the
    // repeat loop-back; that keeps every gap an exact multiple of a unit.
    always_comb begin
        state_nxt  = state;
        pre_nxt    = unit_end ? '0 : pre + PW'(1);
        units_nxt  = unit_end ? units - 3'd1 : units;
        elem_nxt   = elem;
        pat_nxt    = pat;
        rd_nxt     = rd_idx;
        loop_nxt   = loop_gap;
        flush      = 1'b0;
        enter      = 1'b0;
        enter_next = 1'b0;
        end_msg    = 1'b0;

        case (state)
            S_IDLE: begin
                pre_nxt   = '0;
                units_nxt = '0;
                if (start && count != '0) begin
                    state_nxt = S_LOAD;
                    rd_nxt    = '0;
                    loop_nxt  = 1'b0;
                end
            end
            S_LOAD: enter = 1'b1;
            S_MARK: begin
                if (seg_end) begin
                    if (elem != 3'd0) begin
                        state_nxt = S_ELEM_GAP;
                        pre_nxt   = '0;
                        units_nxt = 3'd0;
                        elem_nxt  = elem - 3'd1;
                    end else if (last_sym) begin
                        end_msg = 1'b1;
                    end else if (sym_next == SPACE) begin
                        rd_nxt     = rd_idx + AW'(1);
                        enter      = 1'b1;
                        enter_next = 1'b1;
                    end else begin
                        state_nxt = S_CHAR_GAP;
                        pre_nxt   = '0;
                        units_nxt = 3'd2;
                    end
                end
            end
            S_ELEM_GAP: begin
                if (seg_end) begin
                    state_nxt = S_MARK;
                    pre_nxt   = '0;
                    units_nxt = pat[elem] ? 3'd2 : 3'd0;
                end
            end
            S_CHAR_GAP: begin
                if (seg_end) begin
                    rd_nxt     = rd_idx + AW'(1);
                    enter      = 1'b1;
                    enter_next = 1'b1;
                end
            end
            S_WORD_GAP: begin
                if (seg_end) begin
                    if (loop_gap) begin
                        state_nxt = S_LOAD;
                        rd_nxt    = '0;
                        loop_nxt  = 1'b0;
                    end else if (last_sym) begin
                        end_msg = 1'b1;
                    end else begin
                        rd_nxt     = rd_idx + AW'(1);
                        enter      = 1'b1;
                        enter_next = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                flush     = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (end_msg) begin
            if (repeat_en) begin
                // The first unit is one cycle short: the following LOAD
                // cycle completes the 7-unit loop-back gap.
                state_nxt = S_WORD_GAP;
                pre_nxt   = PW'(1);
                units_nxt = 3'd6;
                loop_nxt  = 1'b1;
            end else begin
                state_nxt = S_DONE;
            end
        end

        if (enter) begin
            pre_nxt = '0;
            if (ent_sym == SPACE) begin
                state_nxt = S_WORD_GAP;
                units_nxt = 3'd6;
                loop_nxt  = 1'b0;
            end else begin
                state_nxt = S_MARK;
                pat_nxt   = ent_pat;
                elem_nxt  = ent_len - 3'd1;
                units_nxt = ent_pat[ent_len - 3'd1] ? 3'd2 : 3'd0;
            end
        end

        if (abort) begin
            state_nxt = S_IDLE;
            flush     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pre      <= '0;
            units    <= '0;
            elem     <= '0;
            pat      <= '0;
            rd_idx   <= '0;
            loop_gap <= 1'b0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pre      <= pre_nxt;
            units    <= units_nxt;
            elem     <= elem_nxt;
            pat      <= pat_nxt;
            rd_idx   <= rd_nxt;
            loop_gap <= loop_nxt;
            err_q    <= wr_offer && (sym_data > SPACE);
            if (flush) begin
                count <= '0;
            end else if (wr_ok) begin
                count <= count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[count[AW-1:0]] <= sym_data;
        end
    end

endmodule

// File: doc/morse_stream_encoder.md
Name: morse_stream_encoder

Overview:
Parametrised successor to the single/multi-digit Morse encoder. Buffers a stream of symbols in an internal FIFO: digits 0-9, letters A-Z and word space. On command, keys them out on one output with standard ITU unit timing. Adds a valid/ready input handshake, configurable unit length and FIFO depth, letter support, abort, and continuous repeat (beacon) mode. Sits between the switch/button front end (or a UART decoder) and the LED/buzzer driver.

Parameters:
UNIT_CYCLES, 10_000_000, clock cycles per Morse time unit (min 2).
DEPTH, 16, FIFO depth in symbols (power of two, 2..64).
CW, $clog2(DEPTH)+1, width of fifo_count (derived, not overridden).

Ports:
clk  input  1  system clock, 100 MHz.
rst_n  input  1  asynchronous active-low reset.
sym_data  input  6  symbol code: 0-9 digits, 10-35 letters A-Z, 36 word space, 37-63 invalid.
sym_valid  input  1  symbol present on sym_data.
sym_ready  output  1  FIFO accepts a write this cycle.
start  input  1  single-cycle pulse that begins keying (debounced/edge-detected upstream).
abort  input  1  stop immediately and flush FIFO.
repeat_en  input  1  replay the buffered message continuously.
key_out  output  1  Morse key: high = mark.
busy  output  1  keying in progress.
done  output  1  one-cycle pulse at normal completion.
err_invalid  output  1  one-cycle pulse when an invalid code is offered.
fifo_count  output  CW  symbols stored.

Behaviour:
- Reset (async assert, sync release): state IDLE; key_out=0, busy=0, done=0, err_invalid=0, fifo_count=0.
- sym_ready = !busy && fifo_count<DEPTH. A write occurs when sym_valid && sym_ready.
- A valid offer with code 37-63 while sym_ready is not stored; err_invalid pulses the next cycle.
- Full FIFO: sym_ready=0, nothing is stored, no error.
- Encoding table: up to 5 elements, MSB first, 1 = dash, plus a length field.
  - Digits use the standard 5-element codes: 0=-----, 5=....., 9=----.
  - Letters use standard ITU codes: A=.-, E=., Q=--.-.
- Timing, in units of UNIT_CYCLES:
  - dot mark = 1 unit; dash mark = 3 units.
  - inter-element gap = 1 unit.
  - gap between two consecutive characters = 3 units.
  - a word-space symbol = 7 units low, with no character gap added on either side.
- Every mark/gap lasts exactly n*UNIT_CYCLES cycles. A unit prescaler and a 3-bit unit counter are reloaded on every element.
- FSM states and transitions:
  - IDLE: exit only on start with fifo_count>0; otherwise start is ignored.
  - LOAD: fetch the symbol at the read pointer and look up its pattern (1 cycle).
  - MARK: key_out=1.
  - ELEM_GAP: key_out=0, after a non-final element.
  - CHAR_GAP: key_out=0, after the final element when the next symbol is a character.
  - WORD_GAP: key_out=0, for a space symbol, or for the loop-back gap in repeat mode.
  - DONE: 1 cycle.
- Latency: start sampled at cycle t → LOAD at t+1 → key_out rises at t+2. busy rises at t+1.
- The read pointer is separate from the FIFO head, so symbols are not popped during keying.
- End of message (last symbol's final mark ends, or last space's gap ends):
  - repeat_en=1, sampled at that moment: WORD_GAP of 7 units, then LOAD from the head. Contents are retained.
  - repeat_en=0: DONE. done=1 for that cycle, key_out=0, the FIFO is flushed, and busy=0 the following cycle.
- No trailing gap is emitted after the last mark.
- abort, in any non-IDLE state: next cycle is IDLE, key_out=0, busy=0, FIFO flushed, no done pulse. abort in IDLE only flushes the FIFO.
- start while busy is ignored.
- Simultaneous start and abort: abort wins.
- Reset mid-operation: immediate return to reset values; key_out drops asynchronously.

Test Plan:
1. UNIT_CYCLES=4; write 5, start → key_out shows five 4-cycle highs separated by 4-cycle lows. done pulses the cycle after the 5th mark falls. fifo_count returns to 0.
2. Write A(10), space(36), E(14); start → key_out pattern is high 4, low 4, high 12, low 28, high 4, then done. busy is high from start+1 until done+1.
3. Fill 16 symbols; offer a 17th → sym_ready=0, fifo_count=16. Offer code 40 with FIFO non-full → err_invalid pulses once, count unchanged.
4. repeat_en=1 with message "7" → the --... pattern repeats with 28-cycle gaps between repetitions and no done. Drop repeat_en → the current pass finishes, then done.
5. abort during the second element's mark → key_out=0 and busy=0 next cycle, fifo_count=0, no done. A new write and start work normally afterwards.
6. Assert rst_n low mid-dash → key_out=0 immediately, all outputs at reset values. start with an empty FIFO afterwards → busy stays 0.
